// File: rtl/player_lives.sv
// ---------------------------------------------------------------------------
// player_lives
//   Round-level game-state tracker, advanced once per 1 Hz tick. Tracks each
//   player's lives and post-hit invulnerability, runs the round countdown and
//   decides the winner. Feeds the HUD renderer and the movement-freeze logic.
//
//   Optional build macro: SUDDEN_DEATH_EN
//     defined   : a timeout with both players alive enters SUDDEN (1 life each,
//                 invulnerability cleared); the first accepted hit decides.
//     undefined : a timeout compares remaining lives (more wins, equal = draw).
//
// Parameters
//   LIVES        starting lives per player (1..3)
//   INVULN_SECS  seconds of immunity after an accepted hit (1..7)
//   ROUND_SECS   round length in seconds (1..255)
//
// Ports
//   clock_1Hz    in   1  game tick; all state updates on its posedge
//   true_reset   in   1  asynchronous, active-high reset
//   round_start  in   1  level, sampled in IDLE to begin the round
//   hitP1/hitP2  in   1  level, player's tile was in an explosion this tick
//   livesP1/P2   out  2  remaining lives
//   invulnP1/P2  out  1  invulnerability timer nonzero
//   time_left    out  8  seconds remaining in the round
//   game_state   out  3  0 IDLE,1 PLAY,2 P1_WIN,3 P2_WIN,4 DRAW,5 SUDDEN
//   freeze       out  1  high in every state except PLAY and SUDDEN
// ---------------------------------------------------------------------------
module player_lives #(
   parameter int unsigned LIVES       = 3,
   parameter int unsigned INVULN_SECS = 2,
   parameter int unsigned ROUND_SECS  = 120
) (
   input  logic       clock_1Hz,
   input  logic       true_reset,
   input  logic       round_start,
   input  logic       hitP1,
   input  logic       hitP2,
   output logic [1:0] livesP1,
   output logic [1:0] livesP2,
   output logic       invulnP1,
   output logic       invulnP2,
   output logic [7:0] time_left,
   output logic [2:0] game_state,
   output logic       freeze
);

   localparam int unsigned LIVES_W = 2;
   localparam int unsigned INV_W   = 3;
   localparam int unsigned TIME_W  = 8;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_PLAY   = 3'd1,
      S_P1_WIN = 3'd2,
      S_P2_WIN = 3'd3,
      S_DRAW   = 3'd4,
      S_SUDDEN = 3'd5
   } state_t;

   state_t               r_state;
   logic [LIVES_W-1:0]   r_lives_p1;
   logic [LIVES_W-1:0]   r_lives_p2;
   logic [INV_W-1:0]     r_inv_p1;
   logic [INV_W-1:0]     r_inv_p2;
   logic [TIME_W-1:0]    r_time;

   state_t               w_state_nxt;
   logic [LIVES_W-1:0]   w_lives_p1_nxt;
   logic [LIVES_W-1:0]   w_lives_p2_nxt;
   logic [INV_W-1:0]     w_inv_p1_nxt;
   logic [INV_W-1:0]     w_inv_p2_nxt;
   logic [TIME_W-1:0]    w_time_nxt;
   logic                 w_active;
   logic                 w_timed;

   // State register
   always_ff @(posedge clock_1Hz or posedge true_reset) begin
      if (true_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Lives, invulnerability and countdown registers
   always_ff @(posedge clock_1Hz or posedge true_reset) begin
      if (true_reset) begin
         r_lives_p1 <= LIVES_W'(LIVES);
         r_lives_p2 <= LIVES_W'(LIVES);
         r_inv_p1   <= '0;
         r_inv_p2   <= '0;
         r_time     <= TIME_W'(ROUND_SECS);
      end else begin
         r_lives_p1 <= w_lives_p1_nxt;
         r_lives_p2 <= w_lives_p2_nxt;
         r_inv_p1   <= w_inv_p1_nxt;
         r_inv_p2   <= w_inv_p2_nxt;
         r_time     <= w_time_nxt;
      end
   end

   // Next-state and datapath update; terminal states simply hold everything
   always_comb begin
      w_state_nxt    = r_state;
      w_lives_p1_nxt = r_lives_p1;
      w_lives_p2_nxt = r_lives_p2;
      w_inv_p1_nxt   = r_inv_p1;
      w_inv_p2_nxt   = r_inv_p2;
      w_time_nxt     = r_time;
      w_active       = (r_state == S_PLAY) || (r_state == S_SUDDEN);
      w_timed        = (r_state == S_PLAY);

      case (r_state)
         S_IDLE: begin
            if (round_start) begin
               w_state_nxt = S_PLAY;
            end
         end

         S_PLAY, S_SUDDEN: begin
            // A running invulnerability timer swallows the hit (not queued)
            if (r_inv_p1 != '0) begin
               w_inv_p1_nxt = r_inv_p1 - INV_W'(1);
            end else if (hitP1 && (r_lives_p1 != '0)) begin
               w_lives_p1_nxt = r_lives_p1 - LIVES_W'(1);
               w_inv_p1_nxt   = INV_W'(INVULN_SECS);
            end

            if (r_inv_p2 != '0) begin
               w_inv_p2_nxt = r_inv_p2 - INV_W'(1);
            end else if (hitP2 && (r_lives_p2 != '0)) begin
               w_lives_p2_nxt = r_lives_p2 - LIVES_W'(1);
               w_inv_p2_nxt   = INV_W'(INVULN_SECS);
            end

            // Countdown saturates at zero; SUDDEN has no timer
            if (w_timed && (r_time != '0)) begin
               w_time_nxt = r_time - TIME_W'(1);
            end

            // Kills are resolved before the timeout
            if ((w_lives_p1_nxt == '0) && (w_lives_p2_nxt == '0)) begin
               w_state_nxt = S_DRAW;
            end else if (w_lives_p1_nxt == '0) begin
               w_state_nxt = S_P2_WIN;
            end else if (w_lives_p2_nxt == '0) begin
               w_state_nxt = S_P1_WIN;
            end else if (w_timed && (w_time_nxt == '0)) begin
`ifdef SUDDEN_DEATH_EN
               w_state_nxt    = S_SUDDEN;
               w_lives_p1_nxt = LIVES_W'(1);
               w_lives_p2_nxt = LIVES_W'(1);
               w_inv_p1_nxt   = '0;
               w_inv_p2_nxt   = '0;
`else
               if (w_lives_p1_nxt > w_lives_p2_nxt) begin
                  w_state_nxt = S_P1_WIN;
               end else if (w_lives_p2_nxt > w_lives_p1_nxt) begin
                  w_state_nxt = S_P2_WIN;
               end else begin
                  w_state_nxt = S_DRAW;
               end
`endif
            end
         end

         default: begin
         end
      endcase
   end

   // Outputs decoded straight from registers
   assign livesP1    = r_lives_p1;
   assign livesP2    = r_lives_p2;
   assign invulnP1   = (r_inv_p1 != '0);
   assign invulnP2   = (r_inv_p2 != '0);
   assign time_left  = r_time;
   assign game_state = r_state;
   assign freeze     = ~((r_state == S_PLAY) || (r_state == S_SUDDEN));

endmodule
